// File: rtl/fifo_drain_pkg.sv
// Shared definitions for the FIFO drain scheduler: FSM state encoding and skid depth.
package fifo_drain_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_BURST = 2'd1;
  localparam state_t ST_DRAIN = 2'd2;
  localparam state_t ST_FLUSH = 2'd3;

  localparam int SKID_DEPTH = 2;

endpackage

// File: rtl/fifo_drain_skid.sv
// Two-entry {data,last} skid between the FIFO read port and the tx stream; zero-latency head, sync clear.
// Upstream must never push when full; the scheduler's issue gate accounts for the word in flight.
module fifo_drain_skid
  import fifo_drain_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clear,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  push_last,
  input  logic                  pop,
  output logic [1:0]            occ,
  output logic [DATA_WIDTH-1:0] head_data,
  output logic                  head_last
);

  logic [DATA_WIDTH:0] mem_q [SKID_DEPTH];
  logic                wr_ptr_q, wr_ptr_d;
  logic                rd_ptr_q, rd_ptr_d;
  logic [1:0]          occ_q, occ_d;
  logic                do_pop;

  assign do_pop = pop & (occ_q != 2'd0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (clear) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      occ_d    = 2'd0;
    end else begin
      if (push)   wr_ptr_d = ~wr_ptr_q;
      if (do_pop) rd_ptr_d = ~rd_ptr_q;
      occ_d = occ_q + {1'b0, push} - {1'b0, do_pop};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      occ_q    <= 2'd0;
      for (int i = 0; i < SKID_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      if (push && !clear) mem_q[wr_ptr_q] <= {push_last, push_data};
    end
  end

  assign occ                    = occ_q;
  assign {head_last, head_data} = mem_q[rd_ptr_q];

endmodule

// File: rtl/fifo_drain_scheduler.sv
// Drains the sync FIFO into the host tx stream as framed bursts; FIFO read to tx_valid is 2 cycles, tx_ready stalls reads.
// Define FIFO_DRAIN_TIMEOUT_EN to add the idle timeout that launches partial bursts of sub-threshold data.
module fifo_drain_scheduler
  import fifo_drain_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int BURST_LEN  = 4,
  parameter int TIMEOUT    = 255,
  parameter int TO_WIDTH   = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic                  flush_req,
  input  logic                  fifo_empty,
  input  logic                  fifo_aempty,
  input  logic [DATA_WIDTH-1:0] fifo_rdata,
  input  logic                  fifo_rdata_valid,
  output logic                  fifo_read_req,
  output logic                  fifo_flush,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_valid,
  output logic                  tx_last,
  input  logic                  tx_ready,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  burst_count
);

  localparam int            IW      = $clog2(BURST_LEN + 1);
  localparam logic [IW-1:0] BL_FULL = IW'(BURST_LEN);
  localparam logic [IW-1:0] BL_LAST = IW'(BURST_LEN - 1);

  if (BURST_LEN < 1) begin : g_bl_chk
    $error("fifo_drain_scheduler: BURST_LEN must be at least 1");
  end
  if (TIMEOUT < 0 || TIMEOUT >= 2 ** TO_WIDTH) begin : g_to_chk
    $error("fifo_drain_scheduler: TIMEOUT must fit in TO_WIDTH bits");
  end

  state_t                 state_q, state_d;
  logic [IW-1:0]          issued_q, issued_d;
  logic                   inflight_q;
  logic                   partial_q, partial_d;
  logic [CNT_WIDTH-1:0]   burst_count_q;

  logic [1:0]             skid_occ;
  logic [DATA_WIDTH-1:0]  skid_data;
  logic                   skid_last;
  logic                   skid_clear;
  logic                   can_issue;
  logic                   arrive;
  logic                   arrive_last;
  logic                   tx_fire;
  logic                   partial_start;

  // Issue gate counts the in-flight word so the 2-entry skid can never overflow.
  assign can_issue = (state_q == ST_BURST) & ~flush_req & ~fifo_empty & (issued_q < BL_FULL)
                   & (({1'b0, skid_occ} + {2'b00, inflight_q}) < 3'(SKID_DEPTH));

  assign skid_clear  = flush_req | (state_q == ST_FLUSH);
  assign arrive      = fifo_rdata_valid & ~skid_clear;
  assign arrive_last = (issued_q == BL_FULL) | (partial_q & fifo_empty);

  assign tx_valid    = (skid_occ != 2'd0);
  assign tx_last     = tx_valid & skid_last;
  assign tx_data     = skid_data;
  assign tx_fire     = tx_valid & tx_ready;
  assign burst_count = burst_count_q;

`ifdef FIFO_DRAIN_TIMEOUT_EN
  logic [TO_WIDTH-1:0] to_q, to_d;
  logic                to_run;

  assign to_run        = (state_q == ST_IDLE) & enable & ~fifo_empty & fifo_aempty;
  assign partial_start = to_run & (to_q == TO_WIDTH'(TIMEOUT));

  always_comb begin
    to_d = '0;
    if (to_run && !partial_start) to_d = to_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) to_q <= '0;
    else          to_q <= to_d;
  end
`else
  assign partial_start = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    partial_d = partial_q;
    if (flush_req) begin
      state_d = ST_FLUSH;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (enable && !fifo_aempty) begin
            state_d   = ST_BURST;
            partial_d = 1'b0;
          end else if (partial_start) begin
            state_d   = ST_BURST;
            partial_d = 1'b1;
          end
        end
        ST_BURST: begin
          // A partial burst ends on the word that empties the FIFO.
          if (can_issue && issued_q == BL_LAST)            state_d = ST_DRAIN;
          else if (partial_q && arrive && fifo_empty)      state_d = ST_DRAIN;
        end
        ST_DRAIN: if (skid_occ == 2'd0 && !inflight_q)    state_d = ST_IDLE;
        ST_FLUSH: state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    fifo_read_req = can_issue;
    fifo_flush    = (state_q == ST_FLUSH);
    busy          = (state_q != ST_IDLE);
  end

  always_comb begin
    issued_d = issued_q + IW'(can_issue);
    if (state_q == ST_IDLE) issued_d = '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      issued_q      <= '0;
      inflight_q    <= 1'b0;
      partial_q     <= 1'b0;
      burst_count_q <= '0;
    end else begin
      issued_q   <= issued_d;
      inflight_q <= can_issue;
      partial_q  <= partial_d;
      if (tx_fire && skid_last) burst_count_q <= burst_count_q + 1'b1;
    end
  end

  fifo_drain_skid #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear     (skid_clear),
    .push      (arrive),
    .push_data (fifo_rdata),
    .push_last (arrive_last),
    .pop       (tx_fire),
    .occ       (skid_occ),
    .head_data (skid_data),
    .head_last (skid_last)
  );

endmodule

// File: tb/tb_fifo_drain_scheduler.sv
// Bench for fifo_drain_scheduler: behavioural sync FIFO, expected-word queue, tx monitor.
module tb_fifo_drain_scheduler;

  localparam int DW     = 16;
  localparam int BL     = 4;
  localparam int AEMPTY = 3;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          enable = 1'b0;
  logic          flush_req = 1'b0;
  logic          fifo_empty = 1'b1;
  logic          fifo_aempty = 1'b1;
  logic [DW-1:0] fifo_rdata = '0;
  logic          fifo_rdata_valid = 1'b0;
  logic          fifo_read_req;
  logic          fifo_flush;
  logic [DW-1:0] tx_data;
  logic          tx_valid;
  logic          tx_last;
  logic          tx_ready = 1'b0;
  logic          busy;
  logic [15:0]   burst_count;

  logic          wr_en = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic [DW-1:0] fq[$];
  int            rd_cnt = 0;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          l;
  } exp_t;
  exp_t exp_q[$];

  int n_checks = 0;
  int n_fail = 0;
  int flush_pulses = 0;
  int exp_bursts = 0;

  always #5 clk = ~clk;

  fifo_drain_scheduler #(
    .DATA_WIDTH (DW),
    .BURST_LEN  (BL),
    .TIMEOUT    (8),
    .TO_WIDTH   (8),
    .CNT_WIDTH  (16)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .enable           (enable),
    .flush_req        (flush_req),
    .fifo_empty       (fifo_empty),
    .fifo_aempty      (fifo_aempty),
    .fifo_rdata       (fifo_rdata),
    .fifo_rdata_valid (fifo_rdata_valid),
    .fifo_read_req    (fifo_read_req),
    .fifo_flush       (fifo_flush),
    .tx_data          (tx_data),
    .tx_valid         (tx_valid),
    .tx_last          (tx_last),
    .tx_ready         (tx_ready),
    .busy             (busy),
    .burst_count      (burst_count)
  );

  // Sync FIFO model: 1-cycle read latency, almost-empty at <= AEMPTY words.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fq.delete();
      fifo_rdata_valid <= 1'b0;
      fifo_empty       <= 1'b1;
      fifo_aempty      <= 1'b1;
    end else begin
      fifo_rdata_valid <= 1'b0;
      if (fifo_flush) begin
        fq.delete();
      end else begin
        if (fifo_read_req && fq.size() > 0) begin
          fifo_rdata       <= fq.pop_front();
          fifo_rdata_valid <= 1'b1;
          rd_cnt++;
        end
        if (wr_en) fq.push_back(wr_data);
      end
      fifo_empty  <= (fq.size() == 0);
      fifo_aempty <= (fq.size() <= AEMPTY);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [DW-1:0] d, input logic expect_it, input logic last);
    exp_t e;
    e.d = d;
    e.l = last;
    if (expect_it) exp_q.push_back(e);
    wr_en   = 1'b1;
    wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic wait_drained(input string name, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (!busy && exp_q.size() == 0) break;
      tick();
    end
    chk(name, {30'b0, busy, exp_q.size() != 0}, 32'd0);
  endtask

  // Monitor: pops the scoreboard on each handshake and checks hold stability under backpressure.
  initial begin
    exp_t          e;
    logic [DW-1:0] held_d;
    logic          held_l;
    logic          holding;
    holding = 1'b0;
    held_d  = '0;
    held_l  = 1'b0;
    forever begin
      @(negedge clk);
      if (fifo_flush) flush_pulses++;
      if (!reset_n) begin
        holding = 1'b0;
        continue;
      end
      if (holding && tx_valid) begin
        chk("hold_data", {16'b0, tx_data}, {16'b0, held_d});
        chk("hold_last", {31'b0, tx_last}, {31'b0, held_l});
      end
      holding = 1'b0;
      if (tx_valid && tx_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_tx: got data %0h last %0b, expected no word", tx_data, tx_last);
        end else begin
          e = exp_q.pop_front();
          chk("tx_data", {16'b0, tx_data}, {16'b0, e.d});
          chk("tx_last", {31'b0, tx_last}, {31'b0, e.l});
        end
      end else if (tx_valid) begin
        holding = 1'b1;
        held_d  = tx_data;
        held_l  = tx_last;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int rd0;
    int fl0;
    int n;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_read_req", {31'b0, fifo_read_req}, 32'd0);
    chk("rst_flush",    {31'b0, fifo_flush},    32'd0);
    chk("rst_tx_valid", {31'b0, tx_valid},      32'd0);
    chk("rst_tx_last",  {31'b0, tx_last},       32'd0);
    chk("rst_busy",     {31'b0, busy},          32'd0);
    chk("rst_tx_data",  {16'b0, tx_data},       32'd0);
    chk("rst_bcount",   {16'b0, burst_count},   32'd0);
    reset_n  = 1'b1;
    tx_ready = 1'b1;
    tick();

    // T1: one full burst, words in write order, last on 4th
    enable = 1'b0;
    for (int i = 0; i < 4; i++) write_word(16'hA001 + 16'(i), 1'b1, i == 3);
    enable = 1'b1;
    wait_drained("t1_drain", 100);
    exp_bursts++;
    chk("t1_bcount", {16'b0, burst_count}, 32'(exp_bursts));

    // T2: tx_ready low for 10 cycles after the first word; reads stall at skid full
    rd0 = rd_cnt;
    for (int i = 0; i < 4; i++) write_word(16'hB001 + 16'(i), 1'b1, i == 3);
    for (n = 0; n < 50 && exp_q.size() != 3; n++) tick();
    chk("t2_first_word", 32'(exp_q.size()), 32'd3);
    tx_ready = 1'b0;
    repeat (10) tick();
    chk("t2_stall_reads", 32'(rd_cnt - rd0), 32'd3);
    chk("t2_stall_valid", {31'b0, tx_valid}, 32'd1);
    tx_ready = 1'b1;
    wait_drained("t2_drain", 100);
    exp_bursts++;
    chk("t2_bcount", {16'b0, burst_count}, 32'(exp_bursts));

`ifdef FIFO_DRAIN_TIMEOUT_EN
    // T3: two sub-threshold words leave after the idle timeout
    write_word(16'hC001, 1'b1, 1'b0);
    write_word(16'hC002, 1'b1, 1'b1);
    repeat (3) tick();
    chk("t3_before_timeout", {31'b0, busy}, 32'd0);
    wait_drained("t3_drain", 100);
    exp_bursts++;
    chk("t3_bcount", {16'b0, burst_count}, 32'(exp_bursts));

    // T4: one extra write during a partial burst extends it to 3 words
    write_word(16'hD001, 1'b1, 1'b0);
    write_word(16'hD002, 1'b1, 1'b0);
    for (n = 0; n < 40 && !busy; n++) tick();
    chk("t4_partial_start", {31'b0, busy}, 32'd1);
    write_word(16'hD003, 1'b1, 1'b1);
    wait_drained("t4_drain", 100);
    exp_bursts++;
    chk("t4_bcount", {16'b0, burst_count}, 32'(exp_bursts));
`else
    // T3: without the timeout, sub-threshold data never leaves
    rd0 = rd_cnt;
    write_word(16'hC001, 1'b0, 1'b0);
    write_word(16'hC002, 1'b0, 1'b0);
    repeat (40) tick();
    chk("t3_no_burst",  {31'b0, busy}, 32'd0);
    chk("t3_no_reads",  32'(rd_cnt - rd0), 32'd0);
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    repeat (2) tick();
    chk("t3_flushed", {31'b0, fifo_empty}, 32'd1);
    chk("t3_bcount", {16'b0, burst_count}, 32'(exp_bursts));
`endif

    // T5: flush_req during word 2 of a burst
    tx_ready = 1'b0;
    rd0 = rd_cnt;
    fl0 = flush_pulses;
    for (int i = 0; i < 4; i++) write_word(16'hE001 + 16'(i), 1'b0, 1'b0);
    for (n = 0; n < 50 && (rd_cnt - rd0) < 2; n++) tick();
    chk("t5_two_reads", 32'(rd_cnt - rd0), 32'd2);
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    chk("t5_flush_pulse", {31'b0, fifo_flush}, 32'd1);
    chk("t5_valid_drop",  {31'b0, tx_valid},   32'd0);
    chk("t5_busy_flush",  {31'b0, busy},       32'd1);
    tick();
    chk("t5_flush_end",   {31'b0, fifo_flush}, 32'd0);
    chk("t5_idle",        {31'b0, busy},       32'd0);
    repeat (3) tick();
    chk("t5_pulse_count", 32'(flush_pulses - fl0), 32'd1);
    chk("t5_bcount",      {16'b0, burst_count}, 32'(exp_bursts));
    chk("t5_fifo_empty",  {31'b0, fifo_empty},  32'd1);
    chk("t5_no_reads",    32'(rd_cnt - rd0),    32'd2);
    tx_ready = 1'b1;

    // T6: asynchronous reset between edges mid-burst
    tx_ready = 1'b0;
    for (int i = 0; i < 4; i++) write_word(16'hF001 + 16'(i), 1'b0, 1'b0);
    for (n = 0; n < 50 && !tx_valid; n++) tick();
    chk("t6_valid_seen", {31'b0, tx_valid}, 32'd1);
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t6_rst_valid",    {31'b0, tx_valid},      32'd0);
    chk("t6_rst_last",     {31'b0, tx_last},       32'd0);
    chk("t6_rst_busy",     {31'b0, busy},          32'd0);
    chk("t6_rst_read_req", {31'b0, fifo_read_req}, 32'd0);
    chk("t6_rst_data",     {16'b0, tx_data},       32'd0);
    chk("t6_rst_bcount",   {16'b0, burst_count},   32'd0);
    exp_bursts = 0;
    tick();
    tick();
    reset_n  = 1'b1;
    tx_ready = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) write_word(16'h6001 + 16'(i), 1'b1, i == 3);
    wait_drained("t6_drain", 100);
    exp_bursts++;
    chk("t6_bcount", {16'b0, burst_count}, 32'(exp_bursts));

    repeat (2) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
